// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported line RAM between
// the instruction-fetch and load/store ports, one transaction at a time, with an ack watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [LINE_W-1:0]   i_rdata,
    output logic                i_rerr,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [LINE_W-1:0]   d_wdata,
    input  logic [LINE_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [LINE_W-1:0]   d_rdata,
    output logic                d_rerr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    output logic [LINE_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [LINE_W-1:0]   mem_rdata
);
    localparam int SW = LINE_W / 8;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                own_q, own_d, last_q, last_d, err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [LINE_W-1:0]   rd_val;
    logic                grant, sel_data;

    always_comb begin
        // gated by RST_N so no grant can leak out while reset is asserted
        grant     = RST_N && state_q == IDLE && (i_req || d_req);
        sel_data  = d_req && !(i_req && last_q);
        rd_val    = (mem_ack && !we_q) ? mem_rdata : '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        last_d    = last_q;
        err_d     = err_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (grant) begin
            state_d = BUSY;
            own_d   = sel_data;
            last_d  = sel_data;
            we_d    = sel_data && d_we;
            addr_d  = sel_data ? d_addr : i_addr;
            wdata_d = sel_data ? d_wdata : '0;
            wstrb_d = sel_data ? d_wstrb : '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 8'd1;
            if (mem_ack || cnt_d == TO) begin
                state_d   = RESP;
                err_d     = !mem_ack;
                i_rdata_d = own_q ? i_rdata_q : rd_val;
                d_rdata_d = own_q ? rd_val : d_rdata_q;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_q     <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            last_q    <= last_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_gnt     = grant && !sel_data;
    assign d_gnt     = grant && sel_data;
    assign mem_req   = state_q == BUSY;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign i_rvalid  = state_q == RESP && !own_q;
    assign d_rvalid  = state_q == RESP && own_q;
    assign i_rerr    = i_rvalid && err_q;
    assign d_rerr    = d_rvalid && err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported, 128-bit-line unified RAM between the CPU's instruction-fetch port and its load/store port.
- Round-robin arbitration; one memory transaction outstanding at a time.
- Sits in my_wrapper between the CPU core and the RAM; the RAM's completion is signalled by a one-cycle ack.
- A timeout watchdog aborts any transaction the memory never acknowledges.

Parameters:
ADDR_W, 4, line-address width (16 lines).
LINE_W, 128, line width in bits; strobe width is LINE_W/8.
TIMEOUT, 255, maximum wait cycles for mem_ack before abort; must be ≥1 and fit 8 bits.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
i_req  in  1  fetch request; held with i_addr until i_gnt.
i_addr  in  ADDR_W  fetch line address.
i_gnt  out  1  one-cycle pulse: fetch request accepted.
i_rvalid  out  1  one-cycle pulse: fetch completed.
i_rdata  out  LINE_W  fetch data, valid with i_rvalid.
i_rerr  out  1  with i_rvalid: fetch timed out.
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data line address.
d_wdata  in  LINE_W  store data.
d_wstrb  in  LINE_W/8  store byte enables.
d_gnt  out  1  one-cycle pulse: data request accepted.
d_rvalid  out  1  one-cycle pulse: load/store completed.
d_rdata  out  LINE_W  load data; zero for stores.
d_rerr  out  1  with d_rvalid: access timed out.
mem_req  out  1  held high until mem_ack or timeout.
mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/LINE_W/LINE_W/8  registered request fields; stable while mem_req is high.
mem_ack  in  1  one-cycle completion pulse from RAM.
mem_rdata  in  LINE_W  read data, valid with mem_ack.

Behaviour:
- Reset (async, RST_N=0):
  - All outputs are 0.
  - State is IDLE, the wait counter is 0, and last_owner = DATA, so fetch wins the first tie.
- State IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the port other than last_owner.
  - On grant: pulse the matching *_gnt in that cycle, latch the fields (fetch forces we=0, wstrb=0), set owner and last_owner, and go to BUSY.
  - With no request, stay in IDLE.
- State BUSY:
  - mem_req=1 starting the cycle after the grant; the wait counter increments each cycle.
  - mem_ack=1: register mem_rdata (0 if we=1) and go to RESP.
  - Counter reaches TIMEOUT without ack: drop mem_req, set the err flag, go to RESP.
  - mem_ack and timeout in the same cycle: the ack wins and err=0.
- State RESP (one cycle):
  - Pulse the owner's *_rvalid with rdata/rerr, clear the counter, go to IDLE.
  - mem_req is 0 in this cycle.
- Latency: grant at cycle 0, mem_req from cycle 1; ack at cycle k gives rvalid at cycle k+1. The next grant comes no earlier than k+2.
- mem_ack while not in BUSY is ignored.
- A requester deasserting req before gnt is legal: no grant and no side effect.
- The port not granted keeps waiting. Under continuous contention, grants strictly alternate.
- *_rdata holds its value between rvalid pulses; it is cleared only by reset.
- Reset mid-transaction: mem_req drops immediately and no rvalid is ever issued for the aborted access.
- Outputs are never X after reset, and only one of i_gnt/d_gnt may pulse per cycle.

Test Plan:
- Fetch only: i_req, i_addr=3; RAM acks 2 cycles after mem_req → i_gnt at cycle 0, mem_req cycles 1-2 with mem_addr=3, i_rvalid cycle 3 with i_rdata=mem_rdata (e.g. 128'h00a00093), i_rerr=0.
- Store: d_we=1, d_addr=5, d_wstrb=16'h0001, d_wdata=...06 → mem_we=1, mem_wstrb=16'h0001; d_rvalid with d_rdata=0.
- Contention: i_req and d_req both held high from reset, 4 transactions → grant order I, D, I, D; each d_rvalid carries the load data and no rvalid pulses twice.
- Timeout: TIMEOUT=4, mem_ack never asserted → mem_req high 4 cycles then 0, d_rvalid=1 with d_rerr=1, then IDLE and the next request is accepted normally.
- Ack/timeout tie: mem_ack exactly on the TIMEOUT cycle → rerr=0, rdata=mem_rdata.
- Reset mid-BUSY: drop RST_N between edges while mem_req=1 → all outputs 0 asynchronously; after release, a simultaneous i_req and d_req grants fetch first.
